// File: rtl/eth_tx_pkg.sv
// Shared constants, types and the checksum patch helper for the TX checksum insert stage.
package eth_tx_pkg;

  // Data word layout: {tlast, tkeep, tdata}
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned KEEP_W   = 8;
  localparam int unsigned KEEP_LSB = 64;
  localparam int unsigned LAST_BIT = 72;
  localparam int unsigned WORD_W   = 73;

  // Meta entry layout: {en, off, sum}
  localparam int unsigned META_W       = 33;
  localparam int unsigned META_SUM_LSB = 0;
  localparam int unsigned META_OFF_LSB = 16;
  localparam int unsigned META_EN_BIT  = 32;

  typedef struct packed {
    logic        en;
    logic [15:0] off;
    logic [15:0] sum;
  } meta_t;

  typedef enum logic [0:0] {StIdle, StStream} rd_state_e;

  // Overlay the checksum onto the lanes whose frame byte position matches the offset.
  // Positions wrap modulo 2^16, so off=0xFFFF puts the low byte at position 0 of the next
  // 64 KiB window; such frames are unsupported anyway.
  function automatic logic [DATA_W-1:0] patch_word(input logic [DATA_W-1:0] data,
                                                   input logic [KEEP_W-1:0] keep,
                                                   input logic [15:0]       ocnt,
                                                   input meta_t             m);
    logic [DATA_W-1:0] res;
    logic [15:0]       pos;
    logic [15:0]       off_lo;
    res    = data;
    off_lo = m.off + 16'd1;
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      pos = ocnt + 16'(i);
      if (m.en && keep[i]) begin
        if (pos == m.off) begin
          res[8*i +: 8] = m.sum[15:8];
        end else if (pos == off_lo) begin
          res[8*i +: 8] = m.sum[7:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/eth_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO with full/empty flags and free count.
module eth_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AddrW:0]   free_o
);

  localparam int unsigned Depth    = 1 << AddrW;
  localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   count_q, count_d;
  logic             wr_fire, rd_fire;

  assign full_o    = (count_q == DepthCnt);
  assign empty_o   = (count_q == '0);
  assign free_o    = DepthCnt - count_q;
  assign rd_data_o = mem[rd_ptr_q];
  assign wr_fire   = wr_en_i & ~full_o;
  assign rd_fire   = rd_en_i & ~empty_o;

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + AddrW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + AddrW'(1);
    unique case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + (AddrW + 1)'(1);
      2'b01:   count_d = count_q - (AddrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since the flags gate visibility
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/eth_csum_insert.sv
// Store-and-forward TX stage: buffers frames, waits for each frame's checksum, patches it in
// at the per-frame byte offset and streams the frame out on AXI4-Stream.
module eth_csum_insert
  import eth_tx_pkg::*;
#(
  parameter int unsigned C_DATA_AWIDTH  = 9,
  parameter int unsigned C_META_AWIDTH  = 4,
  parameter int unsigned C_AFULL_MARGIN = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              data_fifo_wren,
  input  logic [WORD_W-1:0] data_fifo_wdata,
  input  logic [15:0]       CsInsert,
  input  logic              CsEn,
  input  logic [15:0]       TxSum,
  input  logic              Sum_valid,
  output logic              data_fifo_afull,
  output logic              ovf_err,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready
);

  localparam logic [C_DATA_AWIDTH:0] AfullMargin = (C_DATA_AWIDTH + 1)'(C_AFULL_MARGIN);

  // Write-side state
  logic        sof_q, sof_d;
  logic        meta_pend_q, meta_pend_d;
  logic        pend_en_q, pend_en_d;
  logic [15:0] pend_off_q, pend_off_d;
  logic        ovf_q, ovf_d;

  // Read-side state
  rd_state_e   state_q, state_d;
  meta_t       cur_q, cur_d;
  logic [15:0] ocnt_q, ocnt_d;

  // FIFO interfaces
  logic [WORD_W-1:0]      data_rdata;
  logic                   data_full, data_empty, data_pop;
  logic [C_DATA_AWIDTH:0] data_free;
  meta_t                  meta_wdata;
  logic [META_W-1:0]      meta_rdata;
  logic                   meta_full, meta_empty, meta_push, meta_pop;
  logic [C_META_AWIDTH:0] meta_free_unused;
  logic                   data_drop, sum_drop, head_last;

  assign meta_wdata = '{en: pend_en_q, off: pend_off_q, sum: TxSum};
  assign meta_push  = Sum_valid & meta_pend_q & ~meta_full;
  assign sum_drop   = Sum_valid & ~(meta_pend_q & ~meta_full);
  assign data_drop  = data_fifo_wren & data_full;
  assign head_last  = data_rdata[LAST_BIT];

  eth_sync_fifo #(
    .Width (WORD_W),
    .AddrW (C_DATA_AWIDTH)
  ) u_data_fifo (
    .clk_i     (clk),
    .rst_ni    (resetn),
    .wr_en_i   (data_fifo_wren),
    .wr_data_i (data_fifo_wdata),
    .rd_en_i   (data_pop),
    .rd_data_o (data_rdata),
    .full_o    (data_full),
    .empty_o   (data_empty),
    .free_o    (data_free)
  );

  eth_sync_fifo #(
    .Width (META_W),
    .AddrW (C_META_AWIDTH)
  ) u_meta_fifo (
    .clk_i     (clk),
    .rst_ni    (resetn),
    .wr_en_i   (meta_push),
    .wr_data_i (meta_wdata),
    .rd_en_i   (meta_pop),
    .rd_data_o (meta_rdata),
    .full_o    (meta_full),
    .empty_o   (meta_empty),
    .free_o    (meta_free_unused)
  );

  assign data_fifo_afull = (data_free < AfullMargin);
  assign ovf_err         = ovf_q;

  // Frame tracking, pending meta latch and sticky error next-state
  always_comb begin
    sof_d       = sof_q;
    meta_pend_d = meta_pend_q;
    pend_en_d   = pend_en_q;
    pend_off_d  = pend_off_q;
    ovf_d       = ovf_q | data_drop | sum_drop;
    if (data_fifo_wren) sof_d = data_fifo_wdata[LAST_BIT];
    if (Sum_valid) meta_pend_d = 1'b0;
    // A new frame's first beat wins the register even when a sum is consumed this cycle
    if (data_fifo_wren && sof_q) begin
      meta_pend_d = 1'b1;
      pend_en_d   = CsEn;
      pend_off_d  = CsInsert;
    end
  end

  // Write-side registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sof_q       <= 1'b1;
      meta_pend_q <= 1'b0;
      pend_en_q   <= 1'b0;
      pend_off_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sof_q       <= sof_d;
      meta_pend_q <= meta_pend_d;
      pend_en_q   <= pend_en_d;
      pend_off_q  <= pend_off_d;
      ovf_q       <= ovf_d;
    end
  end

  // Read FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Read FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!meta_empty) state_d = StStream;
      StStream: if (data_pop && head_last) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Read FSM outputs
  always_comb begin
    meta_pop      = 1'b0;
    m_axis_tvalid = 1'b0;
    unique case (state_q)
      StIdle:   meta_pop = ~meta_empty;
      StStream: m_axis_tvalid = ~data_empty;
      default:  ;
    endcase
    data_pop = m_axis_tvalid & m_axis_tready;
  end

  // Current-frame checksum context and output byte counter
  always_comb begin
    cur_d  = cur_q;
    ocnt_d = ocnt_q;
    if (meta_pop) begin
      cur_d  = meta_t'(meta_rdata);
      ocnt_d = '0;
    end else if (data_pop) begin
      ocnt_d = ocnt_q + 16'd8;
    end
  end

  // Current-frame registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur_q  <= '0;
      ocnt_q <= '0;
    end else begin
      cur_q  <= cur_d;
      ocnt_q <= ocnt_d;
    end
  end

  // Patched FWFT head; zeroed when not valid so idle outputs stay quiet
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    m_axis_tlast = 1'b0;
    if (m_axis_tvalid) begin
      m_axis_tkeep = data_rdata[KEEP_LSB +: KEEP_W];
      m_axis_tlast = head_last;
      m_axis_tdata = patch_word(data_rdata[DATA_W-1:0], m_axis_tkeep, ocnt_q, cur_q);
    end
  end

endmodule

// File: tb/tb_eth_csum_insert.sv
// Directed bench for eth_csum_insert: insertion, straddling sums, bypass, back-to-back
// frames with stalls, buffer limits and reset mid-frame.
module tb_eth_csum_insert;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        data_fifo_wren = 1'b0;
  logic [72:0] data_fifo_wdata = '0;
  logic [15:0] CsInsert = '0;
  logic        CsEn = 1'b0;
  logic [15:0] TxSum = '0;
  logic        Sum_valid = 1'b0;
  logic        data_fifo_afull, ovf_err;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast, m_axis_tvalid;
  logic        m_axis_tready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  eth_csum_insert u_dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_fifo_wren  (data_fifo_wren),
    .data_fifo_wdata (data_fifo_wdata),
    .CsInsert        (CsInsert),
    .CsEn            (CsEn),
    .TxSum           (TxSum),
    .Sum_valid       (Sum_valid),
    .data_fifo_afull (data_fifo_afull),
    .ovf_err         (ovf_err),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready)
  );

  // Frame content: byte k of a frame seeded with s
  function automatic logic [7:0] raw_byte(input int s, input int k);
    return 8'((s * 31 + k * 7 + 1) & 255);
  endfunction

  function automatic logic [63:0] raw_word(input int s, input int beat);
    logic [63:0] w;
    for (int l = 0; l < 8; l++) w[8*l +: 8] = raw_byte(s, beat * 8 + l);
    return w;
  endfunction

  function automatic logic [7:0] keep_of(input int nbytes, input int beat);
    int rem;
    rem = nbytes - 8 * beat;
    if (rem >= 8) return 8'hFF;
    return 8'((1 << rem) - 1);
  endfunction

  // Expected output word: raw bytes with the sum overlaid at frame bytes off and off+1
  function automatic logic [63:0] exp_word(input int s, input int beat, input int nbytes,
                                           input bit en, input int off, input logic [15:0] sum);
    logic [63:0] w;
    int k;
    w = raw_word(s, beat);
    for (int l = 0; l < 8; l++) begin
      k = beat * 8 + l;
      if (en && k < nbytes && k == off) w[8*l +: 8] = sum[15:8];
      else if (en && k < nbytes && k == off + 1) w[8*l +: 8] = sum[7:0];
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    data_fifo_wren = 1'b0;
    Sum_valid = 1'b0;
    m_axis_tready = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic write_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                            input logic en, input logic [15:0] off);
    data_fifo_wren  = 1'b1;
    data_fifo_wdata = {l, k, d};
    CsEn            = en;
    CsInsert        = off;
    tick();
    data_fifo_wren  = 1'b0;
  endtask

  // Later beats carry different CsEn/CsInsert to confirm only the first beat is sampled
  task automatic write_frame(input int s, input int nbytes, input bit en, input int off);
    int nb;
    nb = (nbytes + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      if (b == 0) write_beat(raw_word(s, b), keep_of(nbytes, b), nb == 1, en, 16'(off));
      else write_beat(raw_word(s, b), keep_of(nbytes, b), b == nb - 1, ~en, 16'(off + 3));
    end
  endtask

  // Sum_valid two cycles after the tlast write
  task automatic send_sum(input logic [15:0] sum);
    tick();
    Sum_valid = 1'b1;
    TxSum     = sum;
    tick();
    Sum_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_vec += 6;
    if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid got %b want 0", m_axis_tvalid); end
    if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast got %b want 0", m_axis_tlast); end
    if (m_axis_tdata !== 64'h0) begin n_err++; $display("FAIL rst_tdata got %h want 0", m_axis_tdata); end
    if (m_axis_tkeep !== 8'h0) begin n_err++; $display("FAIL rst_tkeep got %h want 0", m_axis_tkeep); end
    if (data_fifo_afull !== 1'b0) begin n_err++; $display("FAIL rst_afull got %b want 0", data_fifo_afull); end
    if (ovf_err !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", ovf_err); end
  endtask

  task automatic test_insert_basic();
    logic [63:0] e;
    write_frame(1, 60, 1'b1, 40);
    send_sum(16'hBEEF);
    m_axis_tready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL basic_lat_t1 tvalid got %b want 0", m_axis_tvalid); end
    tick();
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      e = exp_word(1, b, 60, 1'b1, 40, 16'hBEEF);
      n_vec++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== e || m_axis_tkeep !== keep_of(60, b) ||
          m_axis_tlast !== (b == 7)) begin
        n_err++;
        $display("FAIL basic_beat%0d got v=%b d=%h k=%h l=%b want v=1 d=%h k=%h l=%b", b,
                 m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, e, keep_of(60, b), b == 7);
      end
      if (b == 5) begin
        n_vec++;
        if (m_axis_tdata[15:0] !== 16'hEFBE) begin
          n_err++; $display("FAIL basic_lanes01 got %h want efbe", m_axis_tdata[15:0]);
        end
      end
      tick();
    end
    @(negedge clk);
    n_vec++;
    if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL basic_end tvalid got %b want 0", m_axis_tvalid); end
  endtask

  task automatic test_straddle();
    logic [63:0] e;
    write_frame(2, 24, 1'b1, 15);
    send_sum(16'h1234);
    m_axis_tready = 1'b1;
    tick();
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      e = exp_word(2, b, 24, 1'b1, 15, 16'h1234);
      n_vec++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== e || m_axis_tlast !== (b == 2)) begin
        n_err++;
        $display("FAIL straddle_beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", b,
                 m_axis_tvalid, m_axis_tdata, m_axis_tlast, e, b == 2);
      end
      if (b == 1) begin
        n_vec++;
        if (m_axis_tdata[63:56] !== 8'h12) begin n_err++; $display("FAIL straddle_hi got %h want 12", m_axis_tdata[63:56]); end
      end
      if (b == 2) begin
        n_vec++;
        if (m_axis_tdata[7:0] !== 8'h34) begin n_err++; $display("FAIL straddle_lo got %h want 34", m_axis_tdata[7:0]); end
      end
      tick();
    end
  endtask

  task automatic test_disabled();
    write_frame(3, 40, 1'b0, 8);
    send_sum(16'hFFFF);
    m_axis_tready = 1'b1;
    tick();
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      n_vec++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== raw_word(3, b)) begin
        n_err++;
        $display("FAIL bypass_beat%0d got v=%b d=%h want v=1 d=%h", b, m_axis_tvalid, m_axis_tdata,
                 raw_word(3, b));
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int nrx, gap, bi;
    logic stalled;
    logic [63:0] hold_d, e;
    logic hold_l;
    nrx = 0; gap = 0; stalled = 1'b0; hold_d = '0; hold_l = 1'b0;
    m_axis_tready = 1'b0;
    write_frame(4, 64, 1'b1, 20);
    send_sum(16'h0001);
    write_frame(5, 64, 1'b1, 33);
    send_sum(16'h0002);
    for (int c = 0; c < 200 && nrx < 16; c++) begin
      @(negedge clk);
      if (stalled) begin
        n_vec++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hold_d || m_axis_tlast !== hold_l) begin
          n_err++;
          $display("FAIL b2b_stable got v=%b d=%h l=%b want v=1 d=%h l=%b", m_axis_tvalid,
                   m_axis_tdata, m_axis_tlast, hold_d, hold_l);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        bi = nrx % 8;
        e = (nrx < 8) ? exp_word(4, bi, 64, 1'b1, 20, 16'h0001)
                      : exp_word(5, bi, 64, 1'b1, 33, 16'h0002);
        n_vec++;
        if (m_axis_tdata !== e || m_axis_tlast !== (bi == 7) || m_axis_tkeep !== 8'hFF) begin
          n_err++;
          $display("FAIL b2b_beat%0d got d=%h k=%h l=%b want d=%h k=ff l=%b", nrx, m_axis_tdata,
                   m_axis_tkeep, m_axis_tlast, e, bi == 7);
        end
        nrx++;
        stalled = 1'b0;
      end else if (m_axis_tvalid) begin
        stalled = 1'b1;
        hold_d  = m_axis_tdata;
        hold_l  = m_axis_tlast;
      end else begin
        stalled = 1'b0;
        if (nrx == 8) gap++;
      end
      tick();
      m_axis_tready = ~m_axis_tready;
    end
    n_vec += 3;
    if (nrx !== 16) begin n_err++; $display("FAIL b2b_count got %0d want 16", nrx); end
    if (gap !== 1) begin n_err++; $display("FAIL b2b_gap got %0d want 1", gap); end
    if (ovf_err !== 1'b0) begin n_err++; $display("FAIL b2b_ovf got %b want 0", ovf_err); end
  endtask

  task automatic test_afull_ovf();
    int nrx, bad;
    logic [63:0] e;
    do_reset();
    for (int i = 0; i < 512; i++) begin
      write_beat(64'(i), 8'hFF, 1'b0, 1'b1, 16'd8);
      if (i == 503 || i == 504) begin
        @(negedge clk);
        n_vec++;
        if (data_fifo_afull !== (i == 504)) begin
          n_err++; $display("FAIL afull_at%0d got %b want %b", i + 1, data_fifo_afull, i == 504);
        end
      end
    end
    @(negedge clk);
    n_vec++;
    if (ovf_err !== 1'b0) begin n_err++; $display("FAIL full_noovf got %b want 0", ovf_err); end
    write_beat(64'hDEAD, 8'hFF, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    n_vec++;
    if (ovf_err !== 1'b1) begin n_err++; $display("FAIL full_ovf got %b want 1", ovf_err); end
    // Drain: word 1 gets bytes 8/9 zeroed by the sum, and the dropped word must not appear
    send_sum(16'h0000);
    m_axis_tready = 1'b1;
    nrx = 0; bad = 0;
    for (int c = 0; c < 530; c++) begin
      @(negedge clk);
      if (m_axis_tvalid) begin
        e = (nrx == 1) ? 64'h0 : 64'(nrx);
        if (m_axis_tdata !== e) bad++;
        nrx++;
      end
      tick();
    end
    n_vec += 2;
    if (nrx !== 512) begin n_err++; $display("FAIL drain_count got %0d want 512", nrx); end
    if (bad !== 0) begin n_err++; $display("FAIL drain_data got %0d bad words want 0", bad); end
    do_reset();
    @(negedge clk);
    n_vec++;
    if (ovf_err !== 1'b0) begin n_err++; $display("FAIL ovf_cleared got %b want 0", ovf_err); end
    tick();
    Sum_valid = 1'b1;
    TxSum = 16'h5555;
    tick();
    Sum_valid = 1'b0;
    tick();
    @(negedge clk);
    n_vec += 2;
    if (ovf_err !== 1'b1) begin n_err++; $display("FAIL orphan_sum_ovf got %b want 1", ovf_err); end
    if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL orphan_sum_tvalid got %b want 0", m_axis_tvalid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_frame(6, 32, 1'b1, 4);
    send_sum(16'hCAFE);
    m_axis_tready = 1'b1;
    tick();
    tick();
    tick();
    #2;
    resetn = 1'b0;
    #1;
    n_vec++;
    if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL midrst_tvalid got %b want 0", m_axis_tvalid); end
    tick();
    resetn = 1'b1;
    tick();
    tick();
    @(negedge clk);
    n_vec++;
    if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL midrst_empty got %b want 0", m_axis_tvalid); end
    tick();
    write_frame(7, 16, 1'b1, 2);
    send_sum(16'hABCD);
    tick();
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      n_vec++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_word(7, b, 16, 1'b1, 2, 16'hABCD) ||
          m_axis_tlast !== (b == 1)) begin
        n_err++;
        $display("FAIL postrst_beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", b, m_axis_tvalid,
                 m_axis_tdata, m_axis_tlast, exp_word(7, b, 16, 1'b1, 2, 16'hABCD), b == 1);
      end
      tick();
    end
    @(negedge clk);
    n_vec++;
    if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL postrst_end got %b want 0", m_axis_tvalid); end
  endtask

  initial begin
    test_reset();
    test_insert_basic();
    test_straddle();
    test_disabled();
    test_back_to_back();
    test_afull_ovf();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/eth_csum_insert.md
Name: eth_csum_insert

Overview:
- TX stage directly downstream of the checksum engine.
- Stores each frame written to the TX data FIFO (73-bit word: tlast, tkeep, tdata) and waits for that frame's TxSum/Sum_valid.
- Patches the 16-bit checksum into the frame at a per-frame byte offset, then streams the frame out on AXI4-Stream to the MAC.
- Store-and-forward: a frame is never released before its checksum is known.

Parameters:
- C_DATA_AWIDTH, 9, log2 of data buffer depth in 64-bit words (512 words).
- C_META_AWIDTH, 4, log2 of per-frame checksum queue depth (16 frames).
- C_AFULL_MARGIN, 8, free-word threshold below which data_fifo_afull asserts.

Ports:
- clk  in  1  single clock.
- resetn  in  1  asynchronous active-low reset.
- data_fifo_wren  in  1  write strobe; same strobe feeds the checksum engine.
- data_fifo_wdata  in  73  [63:0] tdata, [71:64] tkeep, [72] tlast.
- CsInsert  in  16  byte offset from frame start of checksum high byte; sampled on first beat.
- CsEn  in  1  insertion enable for this frame; sampled on first beat.
- TxSum  in  16  final checksum from the checksum engine.
- Sum_valid  in  1  one-cycle pulse; TxSum valid.
- data_fifo_afull  out  1  free words < C_AFULL_MARGIN.
- ovf_err  out  1  sticky overflow/protocol error.
- m_axis_tdata  out  64  output data.
- m_axis_tkeep  out  8  output byte enables, passed through unchanged.
- m_axis_tlast  out  1  last beat.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset (asynchronous, resetn=0):
  - Both FIFOs empty; sof=1; meta_pend=0; state=IDLE.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0.
  - data_fifo_afull=0, ovf_err=0.
  - Reset mid-frame discards all buffered and partial frames.
- Write side:
  - On wren, push the 73-bit word to the data FIFO.
  - sof sets after reset and after any beat with tlast=1; it clears on any other written beat.
  - On wren with sof=1: latch {CsEn, CsInsert} into the pending-meta register and set meta_pend.
  - wren while the data FIFO is full: word dropped, ovf_err=1.
  - Upstream honours data_fifo_afull.
- Sum side:
  - Sum_valid with meta_pend=1: push {CsEn, CsInsert, TxSum} to the meta FIFO and clear meta_pend.
  - Sum_valid with meta_pend=0, or with the meta FIFO full: entry dropped, ovf_err=1.
  - Sum_valid arrives 2 cycles after the tlast write, so the whole frame is already in the data FIFO when its meta entry appears.
  - If a new frame's first beat coincides with Sum_valid, the meta push uses the old pending value; the new latch wins the register.
- Read FSM:
  - Two states, IDLE and STREAM.
  - IDLE: if the meta FIFO is non-empty, pop it into cur_en, cur_off, cur_sum; clear byte counter ocnt=0; go to STREAM.
  - STREAM: m_axis_tvalid = data FIFO not empty (FWFT head).
  - STREAM: on tvalid&tready, pop a data word and set ocnt += 8.
  - STREAM: if that beat has tlast, go to IDLE.
  - Back-to-back frames have a 1-cycle IDLE bubble.
- Insertion, combinational on the FWFT head, for byte lane i (0..7):
  - If cur_en, and (ocnt+i)==cur_off, and tkeep[i]: output byte = cur_sum[15:8].
  - If cur_en, and (ocnt+i)==cur_off+1, and tkeep[i]: output byte = cur_sum[7:0].
  - Otherwise the byte passes through.
  - A sum that straddles two words (cur_off mod 8 == 7) patches lane 7 of one beat and lane 0 of the next.
  - Offsets beyond the frame length: no patch, no error.
- AXI rule: while tvalid=1 and tready=0, tdata, tkeep and tlast hold stable.
- Arithmetic: ocnt is 16 bits and wraps modulo 2^16; frames above 65535 bytes are unsupported.
- Latency: Sum_valid at cycle T → meta entry visible T+1 → IDLE pop T+1 → first m_axis_tvalid at T+2.

Decomposition:
- Package eth_tx_pkg holds:
  - Word-field constants: DATA_W=64, KEEP_W=8, LAST_BIT=72, WORD_W=73.
  - META_W=33 and the meta field positions.
- One generic sub-module eth_sync_fifo: parameterised width/depth, FWFT, full/empty/free-count, async active-low reset.
  - Instantiated twice: data FIFO 73 bits × 2^C_DATA_AWIDTH; meta FIFO 33 bits × 2^C_META_AWIDTH.

Test Plan:
- 60-byte frame, CsEn=1, CsInsert=40, TxSum=16'hBEEF, tready=1 → beat 5 lanes 0/1 = 8'hBE/8'hEF; all other bytes unchanged; first tvalid 2 cycles after Sum_valid.
- CsInsert=15, TxSum=16'h1234 → beat 1 lane 7 = 8'h12, beat 2 lane 0 = 8'h34.
- CsEn=0, TxSum=16'hFFFF → output identical to input.
- Two back-to-back 64-byte frames with sums 16'h0001 and 16'h0002, tready toggling 50% → each frame carries its own sum; data stable during stalls; exactly one idle cycle between frames.
- Fill 505 words with tready=0 → data_fifo_afull=1. One write beyond full → ovf_err=1, word dropped. Sum_valid with no pending frame → ovf_err=1.
- resetn pulsed low mid-output → tvalid=0 immediately; FIFOs empty; next frame after reset streams correctly.
